// File: rtl/seq_div_pkg.sv
// Shared widths, FSM encoding and saturation constant for the 64-by-32 sequential divider.
package seq_div_pkg;

    localparam int DVD_W = 64;
    localparam int DVS_W = 32;
    localparam int CNT_W = $clog2(DVS_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam logic [DVS_W-1:0] QUOT_SAT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in one dividend bit, trial-subtract the divisor.
module div_step
    import seq_div_pkg::*;
(
    input  logic [DVS_W:0]   prem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVS_W:0]   prem_o,
    output logic             qbit_o
);

    logic [DVS_W+1:0] trial;
    logic [DVS_W:0]   diff;

    // prem_i stays below the divisor, so its top bit is always 0 and the
    // full-width trial equals {prem[DVS_W-1:0], bit}; a difference taken
    // modulo 2^(DVS_W+1) is exact whenever the subtraction is kept.
    always_comb begin
        trial  = {prem_i, bit_i};
        qbit_o = (trial >= {2'b00, divisor_i});
        diff   = trial[DVS_W:0] - {1'b0, divisor_i};
        prem_o = qbit_o ? diff : trial[DVS_W:0];
    end

endmodule

// File: rtl/seq_divider_64by32.sv
// Radix-2 restoring 64/32 divider, one quotient bit per clock with a start/done handshake.
// Optional result self-check enabled by defining SEQ_DIV_SELFCHECK_EN.
module seq_divider_64by32
    import seq_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVS_W-1:0] quotient_o,
    output logic [DVS_W-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             overflow_o,
    output logic             check_err_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVS_W:0]   prem_q, prem_d;
    logic [DVS_W-1:0] shreg_q, shreg_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W-1:0] quot_q, quot_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic [DVS_W:0]   step_prem;
    logic             step_qbit;

    div_step u_step (
        .prem_i    (prem_q),
        .bit_i     (shreg_q[DVS_W-1]),
        .divisor_i (dvs_q),
        .prem_o    (step_prem),
        .qbit_o    (step_qbit)
    );

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        shreg_d    = shreg_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    dvs_d = divisor_i;
                    if (divisor_i == '0) begin
                        state_d    = DONE;
                        quot_d     = QUOT_SAT;
                        rem_d      = dividend_i[DVS_W-1:0];
                        div_zero_d = 1'b1;
                        overflow_d = 1'b0;
                    end else if (dividend_i[DVD_W-1:DVS_W] >= divisor_i) begin
                        state_d    = DONE;
                        quot_d     = QUOT_SAT;
                        rem_d      = '0;
                        div_zero_d = 1'b0;
                        overflow_d = 1'b1;
                    end else begin
                        state_d    = CALC;
                        prem_d     = {1'b0, dividend_i[DVD_W-1:DVS_W]};
                        shreg_d    = dividend_i[DVS_W-1:0];
                        cnt_d      = CNT_W'(DVS_W - 1);
                        div_zero_d = 1'b0;
                        overflow_d = 1'b0;
                    end
                end
            end
            CALC: begin
                // Dividend bits leave at the MSB while quotient bits enter at the LSB.
                prem_d  = step_prem;
                shreg_d = {shreg_q[DVS_W-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = {shreg_q[DVS_W-2:0], step_qbit};
                    rem_d   = step_prem[DVS_W-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prem_q     <= '0;
            shreg_q    <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prem_q     <= prem_d;
            shreg_q    <= shreg_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SEQ_DIV_SELFCHECK_EN
    logic [DVD_W-1:0] dvd_q;
    logic [DVD_W-1:0] recon;
    logic             check_fail;
    logic             check_err_q;

    always_comb begin
        recon      = {{(DVD_W-DVS_W){1'b0}}, quot_q} * {{(DVD_W-DVS_W){1'b0}}, dvs_q}
                   + {{(DVD_W-DVS_W){1'b0}}, rem_q};
        check_fail = (state_q == DONE) && !div_zero_q && !overflow_q &&
                     ((recon != dvd_q) || (rem_q >= dvs_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            check_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                dvd_q <= dividend_i;
            end
            check_err_q <= check_err_q | check_fail;
        end
    end

    assign check_err_o = check_err_q;
`else
    assign check_err_o = 1'b0;
`endif

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = div_zero_q;
    assign overflow_o  = overflow_q;

endmodule
